// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among N_REQ requesters,
// with a one-entry output buffer that rides out register-file stalls and drops X31 writes.
module regfile_write_arbiter #(
   parameter int N_REQ  = 2,
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*ADDR_W-1:0] req_reg,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        req_ready,
   input  logic                    rf_stall,
   output logic                    wr_en,
   output logic [ADDR_W-1:0]       wr_reg,
   output logic [DATA_W-1:0]       wr_data,
   output logic                    busy
);

   localparam int               PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [ADDR_W-1:0] XZR  = '1;

   logic              buf_valid;
   logic [ADDR_W-1:0] buf_reg;
   logic [DATA_W-1:0] buf_data;
   logic [PTR_W-1:0]  rr_ptr;
   logic              run;

   logic              drain;
   logic              can_accept;
   logic              accept;
   logic              found;
   logic [PTR_W-1:0]  idx;
   logic [PTR_W-1:0]  grant_idx;
   logic [N_REQ-1:0]  grant;
   logic [ADDR_W-1:0] sel_reg;
   logic [DATA_W-1:0] sel_data;

   assign drain      = buf_valid & ~rf_stall;
   assign can_accept = ~buf_valid | ~rf_stall;

   // run keeps grants off while reset is low and for the first cycle after release
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = '0;
      if (run && can_accept) begin
         for (int k = 1; k <= N_REQ; k++) begin
            idx = PTR_W'((int'(rr_ptr) + k) % N_REQ);
            if (!found && req_valid[idx]) begin
               found      = 1'b1;
               grant[idx] = 1'b1;
               grant_idx  = idx;
            end
         end
      end
   end

   always_comb begin
      sel_reg  = '0;
      sel_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            sel_reg  = req_reg[i*ADDR_W +: ADDR_W];
            sel_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign accept    = |grant;
   assign req_ready = grant;

   // output buffer stage
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         buf_valid <= 1'b0;
         buf_reg   <= '0;
         buf_data  <= '0;
         rr_ptr    <= PTR_W'(N_REQ - 1);
         run       <= 1'b0;
      end else begin
         run <= 1'b1;
         if (accept) begin
            buf_valid <= 1'b1;
            buf_reg   <= sel_reg;
            buf_data  <= sel_data;
            rr_ptr    <= grant_idx;
         end else if (drain) begin
            buf_valid <= 1'b0;
         end
      end
   end

   // X31 entries still drain, just without a write strobe
   assign wr_en   = drain & (buf_reg != XZR);
   assign wr_reg  = buf_reg;
   assign wr_data = buf_data;
   assign busy    = buf_valid;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, single write, round-robin,
// stall hold, X31 drop and asynchronous reset while stalled.
module tb_regfile_write_arbiter;

   logic         clk = 1'b0;
   logic         reset;
   logic [1:0]   req_valid;
   logic [4:0]   r0, r1;
   logic [63:0]  d0, d1;
   logic [9:0]   req_reg;
   logic [127:0] req_data;
   logic [1:0]   req_ready;
   logic         rf_stall;
   logic         wr_en;
   logic [4:0]   wr_reg;
   logic [63:0]  wr_data;
   logic         busy;

   int n_checks = 0;
   int n_fail   = 0;
   int wr9_seen = 0;
   int bad_ready = 0;

   assign req_reg  = {r1, r0};
   assign req_data = {d1, d0};

   regfile_write_arbiter #(.N_REQ(2), .DATA_W(64), .ADDR_W(5)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_reg   (req_reg),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rf_stall  (rf_stall),
      .wr_en     (wr_en),
      .wr_reg    (wr_reg),
      .wr_data   (wr_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (wr_en && wr_reg == 5'd9) wr9_seen++;
      if (!$onehot0(req_ready) || (req_ready & ~req_valid) != 2'b00) bad_ready++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; rf_stall = 1'b0; req_valid = 2'b11;
      r0 = 5'd1; d0 = 64'hA1; r1 = 5'd2; d1 = 64'hA2;
      #2;
      chk("rst_ready", req_ready, 2'b00);
      chk("rst_wr_en", wr_en, 1'b0);
      chk("rst_wr_reg", wr_reg, 5'd0);
      chk("rst_wr_data", wr_data, 64'd0);
      chk("rst_busy", busy, 1'b0);
      step; step;
      chk("rst_ready_held", req_ready, 2'b00);
      reset = 1'b1;
      #1;
      chk("rel_ready_first", req_ready, 2'b00);
      chk("rel_wr_en_first", wr_en, 1'b0);
      step; #1;

      // round-robin with both requesters valid
      for (int i = 0; i < 4; i++) begin
         chk("rr_ready", req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
         step; #1;
         chk("rr_wr_en", wr_en, 1'b1);
         chk("rr_wr_reg", wr_reg, (i % 2 == 0) ? 5'd1 : 5'd2);
      end
      chk("rr_wr_data", wr_data, 64'hA2);
      req_valid = 2'b00;
      step; #1;
      chk("rr_drain_busy", busy, 1'b0);
      chk("rr_drain_wr_en", wr_en, 1'b0);

      // single write
      r0 = 5'd5; d0 = 64'hDEAD_BEEF; req_valid = 2'b01;
      #1;
      chk("sw_ready", req_ready, 2'b01);
      step; req_valid = 2'b00; #1;
      chk("sw_wr_en", wr_en, 1'b1);
      chk("sw_wr_reg", wr_reg, 5'd5);
      chk("sw_wr_data", wr_data, 64'hDEAD_BEEF);
      chk("sw_busy", busy, 1'b1);
      step; #1;
      chk("sw_after_wr_en", wr_en, 1'b0);
      chk("sw_after_busy", busy, 1'b0);

      // stall with buffered reg 7 and req1 waiting
      r0 = 5'd7; d0 = 64'h77; req_valid = 2'b01;
      #1;
      chk("st_fill_ready", req_ready, 2'b01);
      step;
      rf_stall = 1'b1; req_valid = 2'b10; r1 = 5'd8; d1 = 64'h88;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("st_wr_en", wr_en, 1'b0);
         chk("st_wr_reg", wr_reg, 5'd7);
         chk("st_ready", req_ready, 2'b00);
         chk("st_busy", busy, 1'b1);
         step; #1;
      end
      rf_stall = 1'b0;
      #1;
      chk("st_rel_wr_en", wr_en, 1'b1);
      chk("st_rel_wr_reg", wr_reg, 5'd7);
      chk("st_rel_ready", req_ready, 2'b10);
      step; req_valid = 2'b00; #1;
      chk("st_next_wr_en", wr_en, 1'b1);
      chk("st_next_wr_reg", wr_reg, 5'd8);
      chk("st_next_wr_data", wr_data, 64'h88);
      step; #1;
      chk("st_done_busy", busy, 1'b0);

      // stall with empty buffer still accepts one entry
      rf_stall = 1'b1; r0 = 5'd10; d0 = 64'h10; req_valid = 2'b01;
      #1;
      chk("se_ready", req_ready, 2'b01);
      step; req_valid = 2'b00; #1;
      chk("se_busy", busy, 1'b1);
      chk("se_wr_en", wr_en, 1'b0);
      rf_stall = 1'b0;
      #1;
      chk("se_rel_wr_en", wr_en, 1'b1);
      chk("se_rel_wr_reg", wr_reg, 5'd10);
      step; #1;
      chk("se_done_busy", busy, 1'b0);

      // X31 followed by reg 3
      r0 = 5'd31; d0 = 64'hFF; req_valid = 2'b01;
      #1;
      chk("xzr_ready1", req_ready, 2'b01);
      step;
      r0 = 5'd3; d0 = 64'h33;
      #1;
      chk("xzr_slot_wr_en", wr_en, 1'b0);
      chk("xzr_slot_busy", busy, 1'b1);
      chk("xzr_ready2", req_ready, 2'b01);
      step; req_valid = 2'b00; #1;
      chk("xzr_next_wr_en", wr_en, 1'b1);
      chk("xzr_next_wr_reg", wr_reg, 5'd3);
      step; #1;
      chk("xzr_done_busy", busy, 1'b0);

      // async reset while reg 9 is stalled in the buffer
      r0 = 5'd9; d0 = 64'h99; req_valid = 2'b01;
      #1;
      chk("ar_fill_ready", req_ready, 2'b01);
      step; req_valid = 2'b00; rf_stall = 1'b1; #1;
      chk("ar_busy", busy, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      chk("ar_busy_drop", busy, 1'b0);
      rf_stall = 1'b0;
      #1;
      chk("ar_wr_en_drop", wr_en, 1'b0);
      chk("ar_wr_reg_clr", wr_reg, 5'd0);
      chk("ar_wr_data_clr", wr_data, 64'd0);
      step;
      reset = 1'b1;
      r0 = 5'd4; d0 = 64'h44; r1 = 5'd6; d1 = 64'h66; req_valid = 2'b11;
      #1;
      chk("ar_rel_ready_first", req_ready, 2'b00);
      step; #1;
      chk("ar_first_grant", req_ready, 2'b01);
      step; req_valid = 2'b00; #1;
      chk("ar_wr_reg", wr_reg, 5'd4);
      chk("ar_wr_en", wr_en, 1'b1);
      step; step; #1;

      chk("x9_never_written", wr9_seen, 0);
      chk("ready_onehot_valid", bad_ready, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
